// File: rtl/data_mem_unit.sv
// Multi-cycle load/store unit: drives a byte-wide req/ack memory port and stalls the pipeline
// until the access completes or times out.
module data_mem_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       is_mem_access,
  input  logic       is_store,
  input  logic [7:0] addr,
  input  logic [7:0] store_data,
  output logic       stall,
  output logic [7:0] mem_data,
  output logic       mem_valid,
  output logic       mem_error,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [7:0] LastCnt = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic       err_q, err_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (is_mem_access) begin
          addr_d  = addr;
          wdata_d = store_data;
          we_d    = is_store;
          cnt_d   = 8'd0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        // An ack on the final allowed cycle wins over the timeout.
        if (mem_ack) begin
          state_d = StDone;
          if (!we_q) data_d = mem_rdata;
        end else if (cnt_q == LastCnt) begin
          state_d = StDone;
          err_d   = 1'b1;
          if (!we_q) data_d = 8'hFF;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      we_q    <= 1'b0;
      cnt_q   <= 8'h00;
      data_q  <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign stall     = ((state_q == StIdle) && is_mem_access) || (state_q == StBusy);
  assign mem_req   = (state_q == StBusy);
  assign mem_we    = (state_q == StBusy) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_valid = (state_q == StDone);
  assign mem_data  = data_q;
  assign mem_error = err_q;

endmodule
